divider: RTL and testbench

Multi-cycle integer divider for the RV64M DIV/DIVU/REM/REMU family. It sits beside the combinational ULA in the execute stage. It accepts one operation per start pulse and computes one quotient bit per cycle with a restoring shift/subtract datapath, using the same borrow convention as the ULA subtract path (carry_out = 1 means no borrow). It returns a single result word under a start/done handshake.

---
 rtl/divider_if.sv | 27 ++
 rtl/divider.sv | 156 +++++++++++++++
 tb/tb_divider.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Request/result bundle for the multi-cycle divider.
// Latency: none (pure wiring); all outputs are registered inside the divider.
// Backpressure: master holds start until ready (or the DONE exit edge) accepts it.
interface divider_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         signed_op;
  logic         rem_op;
  logic         ready;
  logic         done;
  logic [N-1:0] Y;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, dividend, divisor, signed_op, rem_op,
    input  ready, done, Y, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor, signed_op, rem_op,
    output ready, done, Y, div_by_zero, overflow
  );
endinterface

// File: rtl/divider.sv
// Restoring shift/subtract divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: done N edges after acceptance; divide-by-zero and signed overflow finish immediately.
// Backpressure: start ignored during RUN; a held start is taken on the edge leaving DONE.
module divider #(
  parameter int N = 64
) (
  input logic      clock,
  input logic      reset,
  divider_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N:0]   rem_q;
  logic [N-1:0] quo_q;
  logic [N-1:0] dvs_mag;
  logic [CW-1:0] cnt;
  logic         sgn_op;
  logic         rem_sel;
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] y_q;
  logic         dbz_q;
  logic         ovf_q;

  // Operand decode at the accepting edge
  logic         in_a_neg;
  logic         in_b_neg;
  logic [N-1:0] in_a_mag;
  logic [N-1:0] in_b_mag;
  logic         in_zero;
  logic         in_ovf;
  logic         in_special;
  logic         accept;
  logic         last_step;

  // Magnitude of the most negative value wraps to 2^(N-1) read as unsigned.
  assign in_a_neg   = bus.signed_op & bus.dividend[N-1];
  assign in_b_neg   = bus.signed_op & bus.divisor[N-1];
  assign in_a_mag   = in_a_neg ? -bus.dividend : bus.dividend;
  assign in_b_mag   = in_b_neg ? -bus.divisor : bus.divisor;
  assign in_zero    = (bus.divisor == '0);
  assign in_ovf     = bus.signed_op & (bus.dividend == {1'b1, {(N-1){1'b0}}}) &
                      (bus.divisor == '1);
  assign in_special = in_zero | in_ovf;

  // The DONE exit edge doubles as an accepting edge so a held start
  // sustains one operation every N+1 cycles.
  assign accept    = bus.start & ((state == IDLE) | (state == DONE));
  assign last_step = (cnt == CW'(N - 1));

  // One restoring step; carry_out = 1 means the subtract did not borrow.
  logic [N:0]   r_sh;
  logic [N+1:0] sub;
  logic         carry_out;
  logic [N:0]   r_step;
  logic [N-1:0] q_step;
  logic [N-1:0] q_res;
  logic [N-1:0] r_res;

  assign r_sh      = {rem_q[N-1:0], quo_q[N-1]};
  assign sub       = {1'b0, r_sh} - {2'b00, dvs_mag};
  assign carry_out = ~sub[N+1];
  assign r_step    = carry_out ? sub[N:0] : r_sh;
  assign q_step    = {quo_q[N-2:0], carry_out};

  // Negating zero yields zero, so a zero result never comes out negative.
  assign q_res = (sgn_op & (a_neg ^ b_neg)) ? -q_step : q_step;
  assign r_res = (sgn_op & a_neg) ? -r_step[N-1:0] : r_step[N-1:0];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = in_special ? DONE : RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = in_special ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result/flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_mag <= '0;
      cnt     <= '0;
      sgn_op  <= 1'b0;
      rem_sel <= 1'b0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      y_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      sgn_op  <= bus.signed_op;
      rem_sel <= bus.rem_op;
      a_neg   <= in_a_neg;
      b_neg   <= in_b_neg;
      dvs_mag <= in_b_mag;
      quo_q   <= in_a_mag;
      rem_q   <= '0;
      cnt     <= '0;
      if (in_zero) begin
        y_q   <= bus.rem_op ? bus.dividend : '1;
        dbz_q <= 1'b1;
        ovf_q <= 1'b0;
      end else if (in_ovf) begin
        y_q   <= bus.rem_op ? '0 : bus.dividend;
        dbz_q <= 1'b0;
        ovf_q <= 1'b1;
      end else begin
        dbz_q <= 1'b0;
        ovf_q <= 1'b0;
      end
    end else if (state == RUN) begin
      rem_q <= r_step;
      quo_q <= q_step;
      cnt   <= cnt + CW'(1);
      if (last_step) y_q <= rem_sel ? r_res : q_res;
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.done        = (state == DONE);
  assign bus.Y           = y_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider at N = 8: directed cases, handshake, reset, random traffic.
// Latency: model predicts done at acceptance + N edges (immediately for special cases).
// Backpressure: model takes a request only once the previous DONE cycle has been reached.
module tb_divider;
  localparam int N = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  divider_if #(.N(N)) bus ();
  divider #(.N(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  int tests   = 0;
  int fails   = 0;
  int printed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // Reference arithmetic straight from the DIV/DIVU/REM/REMU rules.
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic s, input logic rem,
                                  output logic [N-1:0] y, output logic dbz,
                                  output logic ovf, output logic sp);
    int sa;
    int sb;
    logic [N-1:0] q;
    logic [N-1:0] r;
    dbz = 1'b0;
    ovf = 1'b0;
    sp  = 1'b0;
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1; sp = 1'b1;
    end else if (s && a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
      q = a; r = '0; ovf = 1'b1; sp = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = N'(sa / sb);
      r = N'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    y = rem ? r : q;
  endfunction

  // Transaction-level model: edge count, edge at which DONE is entered, held outputs.
  int           e_n    = 0;
  int           d_edge = -1;
  logic [N-1:0] m_y    = '0;
  logic [N-1:0] pend_y = '0;
  logic         m_dbz  = 1'b0;
  logic         m_ovf  = 1'b0;

  always @(posedge clock or negedge reset) begin
    logic [N-1:0] ry;
    logic fd, fo, sp;
    if (!reset) begin
      e_n = 0; d_edge = -1; m_y = '0; m_dbz = 1'b0; m_ovf = 1'b0;
    end else begin
      e_n++;
      if (e_n > d_edge && bus.start === 1'b1) begin
        ref_div(bus.dividend, bus.divisor, bus.signed_op, bus.rem_op, ry, fd, fo, sp);
        pend_y = ry;
        m_dbz  = fd;
        m_ovf  = fo;
        d_edge = e_n + (sp ? 0 : N);
      end
      if (e_n == d_edge) m_y = pend_y;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("ready",       32'(bus.ready),       32'(e_n > d_edge));
      chk("done",        32'(bus.done),        32'(e_n == d_edge));
      chk("Y",           32'(bus.Y),           32'(m_y));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
      chk("overflow",    32'(bus.overflow),    32'(m_ovf));
    end
  end

  task automatic wait_ready(input string nm);
    int cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk({nm, "_ready_wait"}, 32'(bus.ready), 32'd1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic rem, input logic [N-1:0] ey, input logic edbz,
                        input logic eovf, input int poke, input string nm);
    logic [N-1:0] my;
    logic md, mo, msp;
    int cyc;
    int extra;
    ref_div(a, b, s, rem, my, md, mo, msp);
    chk({nm, "_model"}, 32'(my), 32'(ey));
    wait_ready(nm);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    bus.signed_op = s; bus.rem_op = rem;
    @(negedge clock);
    bus.dividend = N'($urandom); bus.divisor = N'($urandom);
    bus.signed_op = 1'($urandom); bus.rem_op = 1'($urandom);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      bus.start = (cyc == poke);
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 32'(cyc), msp ? 32'd0 : 32'(N));
    chk({nm, "_Y"},       32'(bus.Y), 32'(ey));
    chk({nm, "_dbz"},     32'(bus.div_by_zero), 32'(edbz));
    chk({nm, "_ovf"},     32'(bus.overflow), 32'(eovf));
    extra = 0;
    repeat (N + 3) begin
      @(negedge clock);
      if (bus.done === 1'b1) extra++;
    end
    chk({nm, "_extra_done"}, 32'(extra), 32'd0);
    chk({nm, "_Y_hold"},     32'(bus.Y), 32'(ey));
  endtask

  initial begin
    int t;
    int last;
    int seen;
    reset = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    bus.signed_op = 1'b0; bus.rem_op = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_Y",     32'(bus.Y),     32'd0);
    chk("rst_dbz",   32'(bus.div_by_zero), 32'd0);
    chk("rst_ovf",   32'(bus.overflow),    32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op(8'd100,  8'd7,    1'b0, 1'b0, 8'd14,   1'b0, 1'b0, -1, "udiv_q");
    run_op(8'd100,  8'd7,    1'b0, 1'b1, 8'd2,    1'b0, 1'b0, -1, "udiv_r");
    run_op(8'h9C,   8'd7,    1'b1, 1'b0, 8'hF2,   1'b0, 1'b0, -1, "sdiv_negA_q");
    run_op(8'h9C,   8'd7,    1'b1, 1'b1, 8'hFE,   1'b0, 1'b0, -1, "sdiv_negA_r");
    run_op(8'd100,  8'hF9,   1'b1, 1'b0, 8'hF2,   1'b0, 1'b0, -1, "sdiv_negB_q");
    run_op(8'd100,  8'hF9,   1'b1, 1'b1, 8'h02,   1'b0, 1'b0, -1, "sdiv_negB_r");
    run_op(8'd37,   8'd0,    1'b0, 1'b0, 8'hFF,   1'b1, 1'b0, -1, "udz_q");
    run_op(8'd37,   8'd0,    1'b0, 1'b1, 8'd37,   1'b1, 1'b0, -1, "udz_r");
    run_op(8'd37,   8'd0,    1'b1, 1'b0, 8'hFF,   1'b1, 1'b0, -1, "sdz_q");
    run_op(8'd37,   8'd0,    1'b1, 1'b1, 8'd37,   1'b1, 1'b0, -1, "sdz_r");
    run_op(8'h80,   8'hFF,   1'b1, 1'b0, 8'h80,   1'b0, 1'b1, -1, "sovf_q");
    run_op(8'h80,   8'hFF,   1'b1, 1'b1, 8'h00,   1'b0, 1'b1, -1, "sovf_r");
    run_op(8'h80,   8'hFF,   1'b0, 1'b0, 8'h00,   1'b0, 1'b0, -1, "uovf_q");
    run_op(8'h80,   8'hFF,   1'b0, 1'b1, 8'h80,   1'b0, 1'b0, -1, "uovf_r");
    run_op(8'd100,  8'd7,    1'b0, 1'b0, 8'd14,   1'b0, 1'b0,  2, "ignore_start");

    // Held start: done pulses every N+1 cycles
    wait_ready("held");
    bus.start = 1'b1;
    t = 0; last = -1; seen = 0;
    while (seen < 5 && t < 200) begin
      bus.dividend = N'($urandom); bus.divisor = N'($urandom_range(1, 254));
      bus.signed_op = 1'($urandom); bus.rem_op = 1'($urandom);
      @(negedge clock);
      t++;
      if (bus.done === 1'b1) begin
        if (last >= 0) chk("held_gap", 32'(t - last), 32'(N + 1));
        last = t;
        seen++;
      end
    end
    bus.start = 1'b0;
    chk("held_pulses", 32'(seen), 32'd5);

    // Reset in the middle of RUN
    wait_ready("rst_mid");
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    bus.signed_op = 1'b0; bus.rem_op = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.ready), 32'd1);
    chk("rst_mid_Y",     32'(bus.Y),     32'd0);
    chk("rst_mid_done",  32'(bus.done),  32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op(8'd200, 8'd13, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0, -1, "after_rst");

    // Random traffic, including special operands and held/gapped starts
    for (int i = 0; i < 2500; i++) begin
      @(negedge clock);
      bus.start = ($urandom_range(0, 3) != 0);
      bus.signed_op = 1'($urandom);
      bus.rem_op = 1'($urandom);
      case ($urandom_range(0, 7))
        0: begin bus.dividend = N'($urandom); bus.divisor = '0; end
        1: begin bus.dividend = 8'h80; bus.divisor = 8'hFF; end
        2: begin bus.dividend = 8'h80; bus.divisor = N'($urandom); end
        default: begin bus.dividend = N'($urandom); bus.divisor = N'($urandom); end
      endcase
    end
    bus.start = 1'b0;
    repeat (N + 4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
